// File: rtl/dom_sched_pkg.sv
// Shared definitions for the time-shared domain-oriented masked AND scheduler:
// FSM state encoding, share count and the share-pair type.
package dom_sched_pkg;

  localparam int NSHARES = 2;

  typedef logic [NSHARES-1:0] share_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RND  = 2'd1,
    MUL  = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/dom_rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters; the pointer moves past the
// winner only when a grant is actually taken.
module dom_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W-1:0] ptr;
  logic            found;
  int              idx;

  // Scan from the pointer upward, wrapping, and take the first valid requester.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (enable && !found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/dom_and_scheduler.sv
// Shares one first-order DOM masked AND among NUM_REQ requesters: arbitrate,
// fetch one fresh random bit, run the single register stage, return tagged shares.
module dom_and_scheduler
  import dom_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [2*NUM_REQ-1:0]   req_a,
  input  logic [2*NUM_REQ-1:0]   req_b,
  output logic                   rnd_req,
  input  logic                   rnd_valid,
  input  logic                   rnd_in,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [1:0]             res_c,
  output logic [ID_W-1:0]        res_id
);

  state_t          state;
  share_t          a_p0, b_p0;
  logic [ID_W-1:0] id_p0;
  share_t          l_p1;
  share_t          a_sel, b_sel;
  logic [ID_W-1:0] grant_id;
  logic [NUM_REQ-1:0] grant;

  dom_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (state == IDLE),
    .req_valid (req_valid),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  assign req_ready = grant;
  assign rnd_req   = (state == RND);

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[NSHARES*i +: NSHARES];
        b_sel = req_b[NSHARES*i +: NSHARES];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_p0      <= '0;
      b_p0      <= '0;
      id_p0     <= '0;
      l_p1      <= '0;
      res_c     <= '0;
      res_id    <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        // p0: latch the winner's operand shares
        IDLE: begin
          if (|grant) begin
            a_p0  <= a_sel;
            b_p0  <= b_sel;
            id_p0 <= grant_id;
            state <= RND;
          end
        end
        // p1: cross-domain products are re-masked with r before they ever meet
        RND: begin
          if (rnd_valid) begin
            l_p1[0] <= (a_p0[0] & b_p0[1]) ^ rnd_in;
            l_p1[1] <= (a_p0[1] & b_p0[0]) ^ rnd_in;
            state   <= MUL;
          end
        end
        // p2: same-domain inner products fold in the registered cross terms
        MUL: begin
          res_c[0]  <= (a_p0[0] & b_p0[0]) ^ l_p1[0];
          res_c[1]  <= (a_p0[1] & b_p0[1]) ^ l_p1[1];
          res_id    <= id_p0;
          res_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_c     <= '0;
            res_id    <= '0;
            a_p0      <= '0;
            b_p0      <= '0;
            id_p0     <= '0;
            l_p1      <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dom_and_scheduler.sv
// Directed scoreboard bench for dom_and_scheduler (NUM_REQ=4).
module tb_dom_and_scheduler;
  import dom_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [2*NUM_REQ-1:0] req_a;
  logic [2*NUM_REQ-1:0] req_b;
  logic                 rnd_req;
  logic                 rnd_valid;
  logic                 rnd_in;
  logic                 res_valid;
  logic                 res_ready;
  logic [1:0]           res_c;
  logic [ID_W-1:0]      res_id;

  dom_and_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rnd_req   (rnd_req),
    .rnd_valid (rnd_valid),
    .rnd_in    (rnd_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_c     (res_c),
    .res_id    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      c;
  } exp_t;
  exp_t sb[$];

  // DOM AND reference: cross terms masked with r, then folded into the inner terms.
  function automatic logic [1:0] dom_ref(input logic [1:0] a, input logic [1:0] b, input logic r);
    logic l0, l1;
    l0 = (a[0] & b[1]) ^ r;
    l1 = (a[1] & b[0]) ^ r;
    return {(a[1] & b[1]) ^ l1, (a[0] & b[0]) ^ l0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] a, input logic [1:0] b);
    req_valid[i]   = v;
    req_a[2*i +: 2] = a;
    req_b[2*i +: 2] = b;
  endtask

  task automatic wait_res(input string tag, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    assert (ok) else begin
      n_bad++;
      $error("FAIL %s: observed no res_valid within 60 cycles, required res_valid=1", tag);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    n_cmp++;
    assert (sb.size() > 0) else begin
      n_bad++;
      $error("FAIL %s: observed unexpected result id=%0d c=%0h, required none", tag, res_id, res_c);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_id"}, 32'(res_id), 32'(e.id));
      check({tag, "_c"}, 32'(res_c), 32'(e.c));
    end
  endtask

  // Starts at a negedge in IDLE with nothing else valid; ends at a negedge back in IDLE.
  task automatic single_op(input string tag, input int i, input logic [1:0] a, input logic [1:0] b,
                           input logic r, output int lat, output logic [1:0] c_obs,
                           output logic [1:0] l_obs);
    int acc;
    bit ok;
    rnd_valid = 1'b1;
    rnd_in    = r;
    set_req(i, 1'b1, a, b);
    #1;
    check({tag, "_grant"}, 32'(req_ready), 32'(1 << i));
    @(negedge clk);
    acc = cyc;
    set_req(i, 1'b0, 2'b00, 2'b00);
    sb.push_back('{id: ID_W'(i), c: dom_ref(a, b, r)});
    wait_res(tag, ok);
    lat   = cyc - acc;
    c_obs = res_c;
    l_obs = dut.l_p1;
    if (ok) pop_check(tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_drop"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, g, last, acc;
    int exp_seq[5];
    logic [1:0] c_obs, l_obs, c_prev, c_hold;
    logic [ID_W-1:0] id_hold;
    bit ok;

    exp_seq = '{0, 1, 2, 3, 0};
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    rnd_valid = 1'b0; rnd_in = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_c", 32'(res_c), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_rnd_req", 32'(rnd_req), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_ready", 32'(req_ready), 32'd0);
    res_ready = 1'b1;
    #1;
    check("res_ready_ignored", 32'(res_valid), 32'd0);
    res_ready = 1'b0;

    // Single op on requester 0, r=1 and then r=0.
    single_op("t1", 0, 2'b01, 2'b10, 1'b1, lat, c_obs, l_obs);
    check("t1_lat", 32'(lat), 32'd2);
    check("t1_c_const", 32'(c_obs), 32'(2'b10));
    check("t1_l", 32'(l_obs), 32'(2'b10));
    c_prev = c_obs;
    single_op("t2", 0, 2'b01, 2'b10, 1'b0, lat, c_obs, l_obs);
    check("t2_c_const", 32'(c_obs), 32'(2'b01));
    check("t2_parity", 32'(c_obs[0] ^ c_obs[1]), 32'd1);
    check("t2_differs", 32'(c_obs != c_prev), 32'd1);

    // Exhaustive share combinations on requester 2.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int r = 0; r < 2; r++) begin
          single_op("exh", 2, 2'(a), 2'(b), 1'(r), lat, c_obs, l_obs);
          check("exh_parity", 32'(c_obs[0] ^ c_obs[1]), 32'((a[0] ^ a[1]) & (b[0] ^ b[1])));
          check("exh_lat", 32'(lat), 32'd2);
        end

    // All four requesters valid: round-robin order and issue interval.
    // Pointer is 3 after the last requester-2 op, so re-align it by one op on 3.
    single_op("align", 3, 2'b11, 2'b01, 1'b1, lat, c_obs, l_obs);
    rnd_valid = 1'b1; rnd_in = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 2'(i), 2'(3 - i));
    g = 0; last = 0;
    for (int k = 0; k < 40 && g < 5; k++) begin
      #1;
      if (res_valid) pop_check("rr_res");
      if (req_ready != '0) begin
        check("rr_grant", 32'(req_ready), 32'(1 << exp_seq[g]));
        if (g > 0) check("rr_interval", 32'(cyc - last), 32'd4);
        last = cyc;
        sb.push_back('{id: ID_W'(exp_seq[g]),
                       c: dom_ref(2'(exp_seq[g]), 2'(3 - exp_seq[g]), 1'b0)});
        g++;
      end
      @(negedge clk);
    end
    check("rr_count", 32'(g), 32'd5);
    req_valid = '0;
    wait_res("rr_last", ok);
    if (ok) pop_check("rr_last");
    @(negedge clk);
    res_ready = 1'b0;

    // Randomness stall plus result backpressure; pointer is now 1.
    rnd_valid = 1'b0; rnd_in = 1'b1;
    set_req(1, 1'b1, 2'b11, 2'b11);
    set_req(3, 1'b1, 2'b01, 2'b01);
    #1;
    check("st_grant", 32'(req_ready), 32'(4'b0010));
    @(negedge clk);
    acc = cyc;
    set_req(1, 1'b0, 2'b00, 2'b00);
    sb.push_back('{id: ID_W'(1), c: dom_ref(2'b11, 2'b11, 1'b1)});
    check("st_ready0", 32'(req_ready), 32'd0);
    check("st_rnd_req0", 32'(rnd_req), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("st_ready", 32'(req_ready), 32'd0);
      check("st_rnd_req", 32'(rnd_req), 32'd1);
      check("st_no_res", 32'(res_valid), 32'd0);
    end
    rnd_valid = 1'b1;
    set_req(3, 1'b0, 2'b00, 2'b00);
    wait_res("st", ok);
    check("st_lat", 32'(cyc - acc), 32'd7);
    c_hold = res_c; id_hold = res_id;
    if (ok) pop_check("st");
    repeat (3) begin
      @(negedge clk);
      check("st_hold_valid", 32'(res_valid), 32'd1);
      check("st_hold_c", 32'(res_c), 32'(c_hold));
      check("st_hold_id", 32'(res_id), 32'(id_hold));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("st_clr_valid", 32'(res_valid), 32'd0);
    check("st_clr_c", 32'(res_c), 32'd0);
    check("st_clr_id", 32'(res_id), 32'd0);
    check("st_clr_l", 32'(dut.l_p1), 32'd0);
    check("st_clr_ab", 32'({dut.a_p0, dut.b_p0}), 32'd0);

    // Reset while in MUL aborts the op; pointer is now 2.
    rnd_valid = 1'b1; rnd_in = 1'b0;
    set_req(2, 1'b1, 2'b01, 2'b10);
    #1;
    check("ra_grant", 32'(req_ready), 32'(4'b0100));
    @(negedge clk);
    set_req(2, 1'b0, 2'b00, 2'b00);
    @(negedge clk);
    check("ra_in_mul", 32'(dut.state), 32'(MUL));
    rst_n = 1'b0;
    #1;
    check("ra_valid", 32'(res_valid), 32'd0);
    check("ra_rnd_req", 32'(rnd_req), 32'd0);
    check("ra_regs", 32'({dut.a_p0, dut.b_p0, dut.l_p1, dut.id_p0}), 32'd0);
    check("ra_res", 32'({res_c, res_id}), 32'd0);
    check("ra_ptr", 32'(dut.u_arb.ptr), 32'd0);
    check("ra_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ra_quiet", 32'(res_valid), 32'd0);
    end
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 2'b10, 2'b10);
    #1;
    check("ra_next_grant", 32'(req_ready), 32'(4'b0001));
    @(negedge clk);
    req_valid = '0;
    sb.push_back('{id: ID_W'(0), c: dom_ref(2'b10, 2'b10, 1'b0)});
    wait_res("ra_next", ok);
    if (ok) pop_check("ra_next");
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
